// File: rtl/sif_loader.sv
`timescale 1ns/1ps
// sif_loader: burst initiator driving the X and W ports of the sif storage block.
// Accepts write-X / write-W / read-X burst commands, streams write data onto the
// selected port and returns X read data as a single-cycle-valid output stream.
//
// Optional feature: define SIF_LOADER_RANGE_CHK_EN to reject bursts whose last
// address would pass 2^AW-1; undefined, such bursts wrap to address 0.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_op, cmd_base, cmd_len payload
//   wd_valid/wd_ready, wd_data  write-data stream in
//   rd_valid, rd_data           read-data stream out (no backpressure)
//   busy, done, err             status: burst in progress, completion pulse, reject pulse
//   xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, xa_data_rd   X port
//   wa_wr_s, wa_addr, wa_data_wr                        W port
module sif_loader #(
    parameter int unsigned AW     = 16,
    parameter int unsigned DW     = 16,
    parameter int unsigned LW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_base,
    input  logic [LW-1:0] cmd_len,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          xa_wr_s,
    output logic          xa_rd_s,
    output logic [AW-1:0] xa_addr,
    output logic [DW-1:0] xa_data_wr,
    input  logic [DW-1:0] xa_data_rd,
    output logic          wa_wr_s,
    output logic [AW-1:0] wa_addr,
    output logic [DW-1:0] wa_data_wr
);

    localparam int unsigned SW = ((AW > LW) ? AW : LW) + 1;

    localparam logic [1:0] OP_WRX = 2'd0;
    localparam logic [1:0] OP_WRW = 2'd1;
    localparam logic [1:0] OP_RDX = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_DRAIN,
        S_FIN,
        S_REJ
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        op_q, op_d;
    logic [AW-1:0]     base_q, base_d;
    logic [LW-1:0]     rem_q, rem_d;
    logic [LW-1:0]     idx_q, idx_d;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;

    logic          cmd_ready_d, wd_ready_d, busy_d, done_d, err_d;
    logic          rd_valid_d;
    logic [DW-1:0] rd_data_d;
    logic          xa_wr_d, xa_rd_d, wa_wr_d;
    logic [AW-1:0] xa_addr_d, wa_addr_d;
    logic [DW-1:0] xa_data_d, wa_data_d;

    logic          accept, hs, range_bad;
    logic [AW-1:0] beat_addr;

    // Burst end-address check: base + len - 1 beyond the top of the address space.
`ifdef SIF_LOADER_RANGE_CHK_EN
    assign range_bad = (SW'(cmd_base) + SW'(cmd_len)) > (SW'(1) << AW);
`else
    assign range_bad = 1'b0;
`endif

    assign accept    = cmd_valid && cmd_ready;
    assign hs        = wd_valid && wd_ready;
    assign beat_addr = base_q + AW'(idx_q);

    // Next-state and next-output logic; every bus output is a flop fed from here.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        base_d     = base_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        xa_wr_d    = 1'b0;
        xa_rd_d    = 1'b0;
        xa_addr_d  = '0;
        xa_data_d  = '0;
        wa_wr_d    = 1'b0;
        wa_addr_d  = '0;
        wa_data_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    base_d = cmd_base;
                    rem_d  = cmd_len;
                    idx_d  = '0;
                    if (cmd_op == OP_RSV || range_bad) begin
                        state_d = S_REJ;
                    end else if (cmd_len == '0) begin
                        state_d = S_FIN;
                    end else if (cmd_op == OP_RDX) begin
                        // First read strobe goes out directly in the cycle after accept.
                        state_d   = S_RD;
                        xa_rd_d   = 1'b1;
                        xa_addr_d = cmd_base;
                        rem_d     = cmd_len - LW'(1);
                        idx_d     = LW'(1);
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                if (hs) begin
                    if (op_q == OP_WRX) begin
                        xa_wr_d   = 1'b1;
                        xa_addr_d = beat_addr;
                        xa_data_d = wd_data;
                    end else if (op_q == OP_WRW) begin
                        wa_wr_d   = 1'b1;
                        wa_addr_d = beat_addr;
                        wa_data_d = wd_data;
                    end
                    rem_d = rem_q - LW'(1);
                    idx_d = idx_q + LW'(1);
                end else if (rem_q == '0) begin
                    // Last strobe is on the bus now; done follows next cycle.
                    state_d = S_FIN;
                end
            end
            S_RD: begin
                if (rem_q != '0) begin
                    xa_rd_d   = 1'b1;
                    xa_addr_d = beat_addr;
                    rem_d     = rem_q - LW'(1);
                    idx_d     = idx_q + LW'(1);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Pipe empty means the final beat is on rd_valid this cycle.
                if (vpipe_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_REJ:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        wd_ready_d  = (state_d == S_WR) && (rem_d != '0);
        busy_d      = (state_d == S_WR) || (state_d == S_RD) || (state_d == S_DRAIN);
        done_d      = (state_d == S_FIN);
        err_d       = (state_d == S_REJ);

        // Read-valid tracker: bit RD_LAT-1 marks xa_data_rd valid this cycle.
        vpipe_d    = (vpipe_q << 1) | RD_LAT'(xa_rd_s);
        rd_valid_d = vpipe_q[RD_LAT-1];
        rd_data_d  = vpipe_q[RD_LAT-1] ? xa_data_rd : '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            base_q     <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            vpipe_q    <= '0;
            cmd_ready  <= 1'b1;
            wd_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            xa_wr_s    <= 1'b0;
            xa_rd_s    <= 1'b0;
            xa_addr    <= '0;
            xa_data_wr <= '0;
            wa_wr_s    <= 1'b0;
            wa_addr    <= '0;
            wa_data_wr <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            base_q     <= base_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            vpipe_q    <= vpipe_d;
            cmd_ready  <= cmd_ready_d;
            wd_ready   <= wd_ready_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            rd_valid   <= rd_valid_d;
            rd_data    <= rd_data_d;
            xa_wr_s    <= xa_wr_d;
            xa_rd_s    <= xa_rd_d;
            xa_addr    <= xa_addr_d;
            xa_data_wr <= xa_data_d;
            wa_wr_s    <= wa_wr_d;
            wa_addr    <= wa_addr_d;
            wa_data_wr <= wa_data_d;
        end
    end

endmodule

// File: tb/tb_sif_loader.sv
`timescale 1ns/1ps
// tb_sif_loader: two loaders (RD_LAT 1 and 3) on a shared sif X-memory stub.
// Each command's full output trace is predicted cycle by cycle from the burst
// rules (beat schedule, latencies, modulo-2^16 addresses, memory contents).
module tb_sif_loader;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned LW   = 8;
    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    typedef struct packed {
        logic          cmd_ready;
        logic          busy;
        logic          done;
        logic          err;
        logic          wd_ready;
        logic          xa_wr_s;
        logic          xa_rd_s;
        logic [AW-1:0] xa_addr;
        logic [DW-1:0] xa_data_wr;
        logic          wa_wr_s;
        logic [AW-1:0] wa_addr;
        logic [DW-1:0] wa_data_wr;
        logic          rd_valid;
        logic [DW-1:0] rd_data;
    } obs_t;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          sel       = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = 2'd0;
    logic [AW-1:0] cmd_base  = '0;
    logic [LW-1:0] cmd_len   = '0;
    logic          wd_valid  = 1'b0;
    logic [DW-1:0] wd_data   = '0;

    logic cmd_valid0, cmd_valid1, wd_valid0, wd_valid1;
    assign cmd_valid0 = cmd_valid && !sel;
    assign cmd_valid1 = cmd_valid && sel;
    assign wd_valid0  = wd_valid && !sel;
    assign wd_valid1  = wd_valid && sel;

    always #5 clk = ~clk;

    logic          d0_cmd_ready, d0_wd_ready, d0_rd_valid, d0_busy, d0_done, d0_err;
    logic          d0_xa_wr_s, d0_xa_rd_s, d0_wa_wr_s;
    logic [AW-1:0] d0_xa_addr, d0_wa_addr;
    logic [DW-1:0] d0_rd_data, d0_xa_data_wr, d0_wa_data_wr, d0_xa_data_rd;
    logic          d1_cmd_ready, d1_wd_ready, d1_rd_valid, d1_busy, d1_done, d1_err;
    logic          d1_xa_wr_s, d1_xa_rd_s, d1_wa_wr_s;
    logic [AW-1:0] d1_xa_addr, d1_wa_addr;
    logic [DW-1:0] d1_rd_data, d1_xa_data_wr, d1_wa_data_wr, d1_xa_data_rd;

    sif_loader #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid0), .cmd_ready(d0_cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wd_valid(wd_valid0), .wd_ready(d0_wd_ready), .wd_data(wd_data),
        .rd_valid(d0_rd_valid), .rd_data(d0_rd_data),
        .busy(d0_busy), .done(d0_done), .err(d0_err),
        .xa_wr_s(d0_xa_wr_s), .xa_rd_s(d0_xa_rd_s), .xa_addr(d0_xa_addr),
        .xa_data_wr(d0_xa_data_wr), .xa_data_rd(d0_xa_data_rd),
        .wa_wr_s(d0_wa_wr_s), .wa_addr(d0_wa_addr), .wa_data_wr(d0_wa_data_wr)
    );

    sif_loader #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid1), .cmd_ready(d1_cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len),
        .wd_valid(wd_valid1), .wd_ready(d1_wd_ready), .wd_data(wd_data),
        .rd_valid(d1_rd_valid), .rd_data(d1_rd_data),
        .busy(d1_busy), .done(d1_done), .err(d1_err),
        .xa_wr_s(d1_xa_wr_s), .xa_rd_s(d1_xa_rd_s), .xa_addr(d1_xa_addr),
        .xa_data_wr(d1_xa_data_wr), .xa_data_rd(d1_xa_data_rd),
        .wa_wr_s(d1_wa_wr_s), .wa_addr(d1_wa_addr), .wa_data_wr(d1_wa_data_wr)
    );

    obs_t obs0, obs1, obs;
    assign obs0 = {d0_cmd_ready, d0_busy, d0_done, d0_err, d0_wd_ready, d0_xa_wr_s, d0_xa_rd_s,
                   d0_xa_addr, d0_xa_data_wr, d0_wa_wr_s, d0_wa_addr, d0_wa_data_wr,
                   d0_rd_valid, d0_rd_data};
    assign obs1 = {d1_cmd_ready, d1_busy, d1_done, d1_err, d1_wd_ready, d1_xa_wr_s, d1_xa_rd_s,
                   d1_xa_addr, d1_xa_data_wr, d1_wa_wr_s, d1_wa_addr, d1_wa_data_wr,
                   d1_rd_valid, d1_rd_data};
    assign obs  = sel ? obs1 : obs0;

    // Power-on contents of never-written X locations.
    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return DW'(a * 16'd5 + 16'h1234);
    endfunction

    // sif X memory stub, written by dut0, read by both with their own latency.
    bit   [DW-1:0] stub_mem [0:65535];
    bit            stub_vld [0:65535];
    logic [DW-1:0] p1 [0:LAT1-1];

    function automatic logic [DW-1:0] stub_rd(input logic [AW-1:0] a);
        return stub_vld[a] ? stub_mem[a] : fill(a);
    endfunction

    always @(posedge clk) begin
        if (d0_xa_wr_s) begin
            stub_mem[d0_xa_addr] <= d0_xa_data_wr;
            stub_vld[d0_xa_addr] <= 1'b1;
        end
        d0_xa_data_rd <= stub_rd(d0_xa_addr);
        p1[0]         <= stub_rd(d1_xa_addr);
        for (int i = 1; i < int'(LAT1); i++) p1[i] <= p1[i-1];
    end
    assign d1_xa_data_rd = p1[LAT1-1];

    // Reference view of X memory, updated from the commands themselves.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] wdat [0:255];
    int            wgap [0:255];
    obs_t          idle_w;

    task automatic check(input obs_t exp_v, input string tag, input int o);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, o, obs, exp_v);
        end
    endtask

    // Issue one command in the current cycle and compare every following cycle
    // up to and including the one where cmd_ready returns.
    task automatic run_cmd(input bit s, input logic [1:0] op, input logic [AW-1:0] base,
                           input logic [LW-1:0] len, input string tag);
        obs_t          ex [0:127];
        int            hs [0:255];
        int            lat, last, t, n;
        bit            rej;
        logic [AW-1:0] a;
        lat = s ? int'(LAT1) : int'(LAT0);
        n   = int'(len);
        for (int i = 0; i < 128; i++) ex[i] = '0;
        for (int i = 0; i < 256; i++) hs[i] = -1;
        rej = (op == 2'd3);
`ifdef SIF_LOADER_RANGE_CHK_EN
        if (n != 0 && int'(base) + n > 65536) rej = 1'b1;
`endif
        if (rej) begin
            ex[1].err = 1'b1;
            last = 2;
        end else if (n == 0) begin
            ex[1].done = 1'b1;
            last = 2;
        end else if (op == 2'd2) begin
            for (int i = 0; i < n; i++) begin
                a = AW'(int'(base) + i);
                ex[i+1].xa_rd_s     = 1'b1;
                ex[i+1].xa_addr     = a;
                ex[i+2+lat].rd_valid = 1'b1;
                ex[i+2+lat].rd_data  = ref_rd(a);
            end
            for (int o = 1; o <= n + lat + 1; o++) ex[o].busy = 1'b1;
            ex[n+lat+2].done = 1'b1;
            last = n + lat + 3;
        end else begin
            t = 1;
            for (int k = 0; k < n; k++) begin
                t = t + wgap[k];
                hs[k] = t;
                a = AW'(int'(base) + k);
                if (op == 2'd0) begin
                    ex[t+1].xa_wr_s    = 1'b1;
                    ex[t+1].xa_addr    = a;
                    ex[t+1].xa_data_wr = wdat[k];
                    ref_mem[a]         = wdat[k];
                end else begin
                    ex[t+1].wa_wr_s    = 1'b1;
                    ex[t+1].wa_addr    = a;
                    ex[t+1].wa_data_wr = wdat[k];
                end
                t = t + 1;
            end
            for (int o = 1; o <= t - 1; o++) ex[o].wd_ready = 1'b1;
            for (int o = 1; o <= t; o++) ex[o].busy = 1'b1;
            ex[t+1].done = 1'b1;
            last = t + 2;
        end
        ex[last].cmd_ready = 1'b1;

        sel       = s;
        cmd_op    = op;
        cmd_base  = base;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int o = 1; o <= last; o++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_base  = AW'($urandom);
            wd_valid  = 1'b0;
            wd_data   = DW'($urandom);
            for (int k = 0; k < n; k++) begin
                if (hs[k] == o) begin
                    wd_valid = 1'b1;
                    wd_data  = wdat[k];
                end
            end
            check(ex[o], tag, o);
        end
        wd_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_w           = '0;
        idle_w.cmd_ready = 1'b1;

        // Reset values on both instances.
        repeat (3) @(posedge clk);
        #1;
        check(idle_w, "reset_d0", 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check(idle_w, "idle_d0", 0);
        sel = 1'b1;
        #1;
        check(idle_w, "idle_d1", 0);
        sel = 1'b0;
        #1;

        // Write X, back-to-back data.
        for (int k = 0; k < 4; k++) begin
            wdat[k] = DW'(16'h00A0 + k);
            wgap[k] = 0;
        end
        run_cmd(1'b0, 2'd0, 16'h0010, 8'd4, "wrx");

        // Write W with a two-cycle data gap after the first beat.
        for (int k = 0; k < 3; k++) begin
            wdat[k] = DW'(16'h5550 + k);
            wgap[k] = 0;
        end
        wgap[1] = 2;
        run_cmd(1'b0, 2'd1, 16'h0200, 8'd3, "wrw_gap");

        // Read back what the first write stored, both latencies.
        run_cmd(1'b0, 2'd2, 16'h0010, 8'd4, "rdx_lat1");
        run_cmd(1'b1, 2'd2, 16'h0010, 8'd2, "rdx_lat3");

        // Zero length and reserved op.
        run_cmd(1'b0, 2'd0, 16'h0300, 8'd0, "len0");
        run_cmd(1'b0, 2'd3, 16'h0010, 8'd4, "op3");

        // Burst crossing the top of the address space.
        for (int k = 0; k < 4; k++) begin
            wdat[k] = DW'(16'hC0DE + k);
            wgap[k] = 0;
        end
        run_cmd(1'b0, 2'd0, 16'hFFFE, 8'd4, "wrap");
        run_cmd(1'b0, 2'd2, 16'hFFFE, 8'd4, "wrap_rd");

        // Reset in the middle of a read burst: nothing further may come out.
        sel       = 1'b0;
        cmd_op    = 2'd2;
        cmd_base  = 16'h0040;
        cmd_len   = 8'd8;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check(idle_w, "rst_mid", 4);
        for (int o = 5; o < 10; o++) begin
            @(posedge clk);
            #1;
            check(idle_w, "rst_after", o);
        end

        // Randomized commands on both instances.
        for (int n = 0; n < 40; n++) begin
            bit            s;
            logic [1:0]    op;
            logic [AW-1:0] base;
            logic [LW-1:0] len;
            s    = ($urandom_range(0, 5) == 0);
            op   = s ? 2'd2 : (($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)));
            len  = LW'($urandom_range(0, 8));
            base = ($urandom_range(0, 3) == 0) ? AW'(16'hFFF8 + $urandom_range(0, 7))
                                               : AW'($urandom_range(0, 63));
            for (int k = 0; k < 8; k++) begin
                wdat[k] = DW'($urandom);
                wgap[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            run_cmd(s, op, base, len, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sif_loader.md
# sif_loader

Bus initiator for the `sif` storage interface; the driving end of the X and W ports. It accepts burst commands (write X, write W, read X) over a valid/ready command port. It moves write data from a stream source into `sif` and returns X read data as an output stream. It sits between the control path and `sif`, replacing testbench-style direct port driving.

## Interface
- `AW`, 16: address width of the X/W ports.
- `DW`, 16: data width of the X/W ports.
- `LW`, 8: burst length field width.
- `RD_LAT`, 1: cycles from the cycle where `xa_rd_s` is high to the cycle where `xa_data_rd` is valid (1..4).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when both high.
- `cmd_op`  in  2  0 = write X, 1 = write W, 2 = read X, 3 = reserved (rejected).
- `cmd_base`  in  AW  first address.
- `cmd_len`  in  LW  beat count; 0 is legal.
- `wd_valid`  in  1  write-data beat present.
- `wd_ready`  out  1  write-data beat accepted when both high.
- `wd_data`  in  DW  write data.
- `rd_valid`  out  1  read beat valid, single cycle; no backpressure.
- `rd_data`  out  DW  read data.
- `busy`  out  1  high from acceptance until `done`.
- `done`  out  1  one-cycle pulse at command completion.
- `err`  out  1  one-cycle pulse on a rejected command.
- `xa_wr_s`, `xa_rd_s`  out  1  X write and read strobes.
- `xa_addr`  out  AW  X address.
- `xa_data_wr`  out  DW  X write data.
- `xa_data_rd`  in  DW  X read data.
- `wa_wr_s`  out  1  W write strobe.
- `wa_addr`  out  AW  W address.
- `wa_data_wr`  out  DW  W write data.

## Operation
- FSM states:
  - IDLE: `cmd_ready` = 1. On accept, latch op/base/len, set `busy`, and go to WR, RD or FIN. Go to FIN when `cmd_len` = 0. Go to REJ for op 3.
  - WR: `wd_ready` = 1 while the remaining count is greater than 0. Each handshake registers one strobe on the selected port (`xa_wr_s` or `wa_wr_s`) next cycle, with addr = base + beat index and data = `wd_data`. After the last handshake, go to FIN.
  - RD: issue `xa_rd_s` every cycle, addr = base + index, for `len` cycles, then go to DRAIN.
  - DRAIN: wait until the RD_LAT-deep valid shift register is empty and the last beat is output, then go to FIN.
  - FIN: `done` = 1 for one cycle, `busy` drops, go to IDLE.
  - REJ: `err` = 1 for one cycle, go to IDLE; no bus activity.
- All bus outputs are registered. Strobes are single-cycle per beat. The read and write strobes are never both high.
- Address arithmetic is modulo 2^AW (see Configuration).
- Beats are returned in issue order; `rd_data` is the registered `xa_data_rd`.
- Unselected port outputs hold 0 (addr/data zeroed when their strobe is low).

## Timing
- Reset values of all outputs are 0, except `cmd_ready`, which is 1 (IDLE). Reset mid-burst abandons the burst immediately: no `done`, and in-flight read data is discarded.
- Accept at edge t: first strobe at the earliest in cycle t+1 (RD), or the cycle after the first `wd` handshake (WR).
- Read: a strobe in cycle c gives `xa_data_rd` valid in c+RD_LAT and `rd_valid` in c+RD_LAT+1.
- `done` fires:
  - write: the cycle after the last strobe;
  - read: the cycle after the last `rd_valid`;
  - len = 0: cycle t+1.
- Back-to-back: a new command is accepted in the cycle `done` is high? No. IDLE is re-entered the cycle after `done`, and `cmd_ready` rises then.
- `wd_valid` gaps insert strobe-free cycles; addresses do not advance during gaps.

## Configuration
- `SIF_LOADER_RANGE_CHK_EN` defined: commands with base + len − 1 > 2^AW − 1 go to REJ (`err` pulse, no `done`, no bus activity).
- `SIF_LOADER_RANGE_CHK_EN` undefined: such commands execute with the address wrapping to 0, and `err` is tied to 0 except for op 3.

## Test plan
- Write X, base 0x0010, len 4, data 0xA0..0xA3 streamed back-to-back -> `xa_wr_s` high 4 consecutive cycles, addr 0x10..0x13, `done` one cycle after the last strobe; `wa_*` stay 0.
- Write W, base 0x0200, len 3, `wd_valid` low for 2 cycles between beats 1 and 2 -> `wa_wr_s` pattern 1,0,0,1,1 (gap cycles strobe-free); addresses 0x200, 0x201, 0x202.
- Read X, base 0x0010, len 4, RD_LAT = 1, after the first test -> `xa_rd_s` 4 cycles; `rd_valid` 4 cycles starting 2 cycles after the first strobe; `rd_data` 0xA0..0xA3; then `done`.
- Read X with RD_LAT = 3, len 2 -> `rd_valid` at strobe cycle + 4; `busy` stays high through DRAIN.
- len = 0 command -> `done` at t+1, no strobes. Op 3 -> `err` pulse, no `done`.
- Write X, base 0xFFFE, len 4 -> with the macro: `err`, no strobes; without the macro: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001. Also assert `rst` mid-burst -> all strobes 0 next cycle and `cmd_ready` = 1.
